// File: rtl/mc_alu_pkg.sv
// Shared types for the multi-cycle ALU: op codes, FSM states and default width.
package mc_alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_ADDU = 4'h1,
    OP_SUB  = 4'h2,
    OP_SUBU = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_NOR  = 4'h7,
    OP_SLT  = 4'h8,
    OP_SLTU = 4'h9,
    OP_EQ   = 4'hA,
    OP_SLL  = 4'hB,
    OP_SRL  = 4'hC,
    OP_SRA  = 4'hD,
    OP_MULU = 4'hE,
    OP_RSVD = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mc_alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one partial product per step,
// WIDTH steps per product. finish/product_nxt describe the step in progress.
module mc_alu_mul_seq
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               finish,
  output logic [2*WIDTH-1:0] product_nxt
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   sum;

  // lo_q starts as the multiplier and fills with product bits from the top.
  assign sum         = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
  assign product_nxt = {sum, lo_q[WIDTH-1:1]};
  assign finish      = step && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      mcand_q <= a;
      hi_q    <= '0;
      lo_q    <= b;
      cnt_q   <= '0;
    end else if (step) begin
      {hi_q, lo_q} <= product_nxt;
      cnt_q        <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mc_alu_core.sv
// Registered ALU with start/done handshake. Define MC_ALU_MUL_EN to build the
// iterative MULU path; without it op E is reported illegal in one cycle.
module mc_alu_core
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic             alu_wr;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_zero, alu_ovf, alu_ill;
  logic [SHW-1:0]   shamt;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[SHW-1:0];

`ifdef MC_ALU_MUL_EN
  logic               mul_load, mul_step, mul_finish, mul_wr;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   result_hi_q;

  mc_alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk         (clk),
    .rst         (rst),
    .load        (mul_load),
    .step        (mul_step),
    .a           (a),
    .b           (b),
    .finish      (mul_finish),
    .product_nxt (mul_prod)
  );

  assign busy      = (state_q == ST_RUN);
  assign result_hi = result_hi_q;
`else
  assign busy      = 1'b0;
  assign result_hi = '0;
`endif

  assign done = (state_q == ST_DONE);

  // Single-cycle datapath; EQ reports equality on zero, not result == 0.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADDU: alu_res = sum;
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUBU: alu_res = diff;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, a == b};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      default: alu_ill = 1'b1;
    endcase
    alu_zero = (op_e'(op) == OP_EQ) ? (a == b) : (alu_res == '0);
  end

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    alu_wr  = 1'b0;
`ifdef MC_ALU_MUL_EN
    mul_load = 1'b0;
    mul_step = 1'b0;
    mul_wr   = 1'b0;
`endif
    case (state_q)
      ST_RUN: begin
`ifdef MC_ALU_MUL_EN
        mul_step = 1'b1;
        if (mul_finish) begin
          state_d = ST_DONE;
          mul_wr  = 1'b1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        if (start) begin
`ifdef MC_ALU_MUL_EN
          if (op_e'(op) == OP_MULU) begin
            state_d  = ST_RUN;
            mul_load = 1'b1;
          end else begin
            state_d = ST_DONE;
            alu_wr  = 1'b1;
          end
`else
          state_d = ST_DONE;
          alu_wr  = 1'b1;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Result registers only move when a request completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      result  <= '0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
      illegal <= 1'b0;
`ifdef MC_ALU_MUL_EN
      result_hi_q <= '0;
`endif
    end else if (alu_wr) begin
      result  <= alu_res;
      zero    <= alu_zero;
      ovf     <= alu_ovf;
      illegal <= alu_ill;
`ifdef MC_ALU_MUL_EN
      result_hi_q <= '0;
    end else if (mul_wr) begin
      result      <= mul_prod[WIDTH-1:0];
      result_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
      zero        <= (mul_prod[WIDTH-1:0] == '0);
      ovf         <= 1'b0;
      illegal     <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_mc_alu_core.sv
// Directed bench for mc_alu_core; MULU checks follow MC_ALU_MUL_EN.
module tb_mc_alu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done, zero, ovf, illegal;
  logic [31:0] result, result_hi;

  int n_total = 0;
  int n_bad   = 0;

  mc_alu_core #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request for exactly one edge, then return #1 after that edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] res, input logic [31:0] hi,
                            input logic z, input logic o, input logic ill);
    check({tag, ".done"},    done,      1'b1);
    check({tag, ".busy"},    busy,      1'b0);
    check({tag, ".result"},  result,    res);
    check({tag, ".hi"},      result_hi, hi);
    check({tag, ".zero"},    zero,      z);
    check({tag, ".ovf"},     ovf,       o);
    check({tag, ".illegal"}, illegal,   ill);
  endtask

  initial begin
    int busy_cnt;
    int cyc;
    int done_cnt;

    rst = 1'b1; start = 1'b0; op = 4'h0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.result", result, 32'h0);
    check("rst.hi", result_hi, 32'h0);
    check("rst.zero", zero, 1'b0);
    check("rst.ovf", ovf, 1'b0);
    check("rst.illegal", illegal, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(4'h0, 32'h7FFF_FFFF, 32'h0000_0001);
    expect_out("add_ovf", 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("add_ovf.done_pulse", done, 1'b0);
    check("add_ovf.held", result, 32'h8000_0000);

    issue(4'h3, 32'd5, 32'd7);
    expect_out("subu", 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 1'b0);
    issue(4'h2, 32'h8000_0000, 32'h1);
    expect_out("sub_ovf", 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(4'h8, 32'hFFFF_FFFF, 32'h1);
    expect_out("slt", 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
    issue(4'h9, 32'hFFFF_FFFF, 32'h1);
    expect_out("sltu", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    issue(4'hA, 32'h1234, 32'h1234);
    expect_out("eq", 32'h1, 32'h0, 1'b1, 1'b0, 1'b0);
    issue(4'hA, 32'h1234, 32'h1235);
    expect_out("neq", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    issue(4'hD, 32'h8000_0000, 32'h24);
    expect_out("sra", 32'hF800_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    issue(4'hB, 32'h1, 32'd31);
    expect_out("sll", 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    issue(4'hC, 32'h8000_0000, 32'h21);
    expect_out("srl", 32'h4000_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    issue(4'h7, 32'h0, 32'h0);
    expect_out("nor", 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0);
    issue(4'h4, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    expect_out("and", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // start held over three requests: one done per clock
    op = 4'h0; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    expect_out("b2b_add", 32'd7, 32'h0, 1'b0, 1'b0, 1'b0);
    op = 4'h6; a = 32'h0000_F0F0; b = 32'h0000_0FF0;
    @(posedge clk); #1;
    expect_out("b2b_xor", 32'h0000_FF00, 32'h0, 1'b0, 1'b0, 1'b0);
    op = 4'hF; a = 32'h5; b = 32'h6;
    @(posedge clk); #1;
    expect_out("b2b_rsvd", 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b.idle_done", done, 1'b0);

`ifdef MC_ALU_MUL_EN
    issue(4'hE, 32'hFFFF_FFFF, 32'h2);
    busy_cnt = 0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      if (cyc == 5) begin
        op = 4'h0; a = 32'h0; b = 32'h0; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check("mulu.done_cycle", cyc, 33);
    check("mulu.busy_cycles", busy_cnt, 32);
    expect_out("mulu", 32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("mulu.done_pulse", done, 1'b0);
    check("mulu.held_hi", result_hi, 32'h1);

    issue(4'hE, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    #1;
    check("abort.busy_before", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.busy", busy, 1'b0);
    check("abort.done", done, 1'b0);
    check("abort.result", result, 32'h0);
    check("abort.hi", result_hi, 32'h0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort.no_done", done_cnt, 0);
`else
    issue(4'hE, 32'hFFFF_FFFF, 32'h2);
    expect_out("mulu_off", 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("mulu_off.done_pulse", done, 1'b0);
    check("mulu_off.busy", busy, 1'b0);

    issue(4'h1, 32'h1, 32'h1);
    check("rst2.before", result, 32'h2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst2.done", done, 1'b0);
    check("rst2.result", result, 32'h0);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("rst2.no_done", done_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_alu_core.md
# mc_alu_core

Parametrised, registered ALU for the multi-cycle datapath. It latches operands on a start handshake, executes single-cycle ops in one clock and an optional iterative unsigned multiply over WIDTH clocks, then presents a registered result with flags and a one-cycle done pulse. It sits between the A/B operand path and the result/writeback bus, and replaces the loose operand latches and output-enable strobe with a synchronous handshake.

## Interface
- WIDTH, 32, datapath width; must be ≥ 8 and a power of two
- SHW, $clog2(WIDTH), shift-amount width, derived
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when state != RUN
- op  in  4  operation code (encoding below)
- a  in  WIDTH  operand A, latched with start
- b  in  WIDTH  operand B, latched with start
- busy  out  1  high while state == RUN
- done  out  1  one-cycle pulse, result/flags valid
- result  out  WIDTH  low result word, held until next done
- result_hi  out  WIDTH  high word of MULU, else 0
- zero  out  1  result == 0; for EQ, a == b
- ovf  out  1  signed overflow, ADD/SUB only
- illegal  out  1  unsupported op accepted

## Operation
- Op codes: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT (signed), 9 SLTU, A EQ, B SLL, C SRL, D SRA, E MULU, F reserved.
- Shifts use b[SHW-1:0] only; upper bits of b are ignored.
- SLT/SLTU/EQ produce 1 or 0 in result[0], with zeros in the upper bits. EQ result = (a == b).
- ovf: ADD sets it on sign(a)==sign(b)!=sign(sum). SUB sets it on sign(a)!=sign(b) and sign(diff)!=sign(a). All other ops clear it.
- MULU: full 2·WIDTH unsigned product; result = low word, result_hi = high word.
- op F, or E with the multiplier compiled out, gives result 0, result_hi 0, zero 1, ovf 0, illegal 1.
- States:
  - IDLE → DONE on start with a single-cycle op.
  - IDLE → RUN on start with MULU.
  - RUN → DONE after WIDTH iterations.
  - DONE → IDLE with no start; DONE → DONE or RUN with start (back-to-back accepted).
- start while in RUN is ignored; operands are not re-latched.
- Reset: state IDLE; busy, done, ovf, illegal = 0; result, result_hi = 0; zero = 0. Reset during RUN aborts the multiply and produces no done.
- Outputs change only on the cycle done is asserted.

## Timing
- start at edge N with a single-cycle op: done = 1 and outputs valid in cycle N+1.
- start at edge N with MULU: busy = 1 for cycles N+1 .. N+WIDTH; done in cycle N+WIDTH+1, with busy = 0.
- Throughput is one single-cycle op per clock when start is held through DONE.
- done never asserts on two consecutive cycles for the same request.

## Configuration
- MC_ALU_MUL_EN defined: iterative shift-add multiplier instantiated; op E = MULU with the latency above.
- MC_ALU_MUL_EN undefined: no multiplier, RUN state unreachable, busy tied 0, result_hi tied 0, op E flagged illegal with 1-cycle latency.

## Structure
- Package mc_alu_pkg holds:
  - op code enum (4 bits)
  - state enum IDLE/RUN/DONE
  - default WIDTH constant
- Sub-module mc_alu_mul_seq: iterative unsigned multiplier with load/step/finish signals and a WIDTH-cycle iteration counter. Instantiated only under MC_ALU_MUL_EN.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, ovf 1, zero 0, done exactly one cycle after start.
- SUBU 5 − 7 → 0xFFFFFFFE, ovf 0. SLT a=0xFFFFFFFF, b=1 → 1. SLTU same operands → 0. EQ a=b=0x1234 → result 1, zero 1.
- SRA 0x80000000 with b=0x24 → 0xF8000000 (shift amount 4). SLL 1 with b=31 → 0x80000000.
- MULU 0xFFFFFFFF × 2 (macro on) → result 0xFFFFFFFE, result_hi 1, busy for 32 cycles, done at start+33. A start issued mid-RUN is ignored.
- Reset asserted at RUN cycle 10 → next cycle busy 0, done 0, result 0. No done follows.
- start held across three cycles with ADD, XOR, op F → three consecutive done pulses with the correct results; the third has illegal 1 and result 0. With the macro off, op E → illegal 1 one cycle later.
